// File: rtl/rv_isa_pkg.sv
// rv_isa_pkg: RV32I encoding constants shared by the instruction encoder and
// the control unit's decode path.
//   fmt_e       - instruction format selector carried on req_fmt (values 6/7 are illegal)
//   OP_*        - 7-bit major opcodes
//   ERR_*       - err_code values reported by instr_encoder
package rv_isa_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_FMT   = 2'd1;
  localparam logic [1:0] ERR_OPC   = 2'd2;
  localparam logic [1:0] ERR_RANGE = 2'd3;

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational RV32I field packer and legality checker.
//   fmt/opcode/func3/func7/rd/rs1/rs2/imm - decoded instruction fields
//   word - packed 32-bit machine word (only meaningful when ok)
//   ok   - request is legal and may be written
//   code - ERR_* reason; priority is format, then opcode, then immediate range
module instr_pack
  import rv_isa_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        ok,
  output logic [1:0]  code
);

  logic fmt_ok;
  logic opc_ok;
  logic rng_ok;
  logic is_shift;
  logic fits12;
  logic fits13;
  logic fits21;

  // A signed value fits N bits when every bit from N-1 upward equals the sign.
  assign fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);

  assign is_shift = (opcode == OP_IMM) && ((func3 == 3'b001) || (func3 == 3'b101));

  always_comb begin
    fmt_ok = 1'b1;
    opc_ok = 1'b0;
    rng_ok = 1'b1;
    word   = '0;
    case (fmt_e'(fmt))
      FMT_R: begin
        opc_ok = (opcode == OP_REG);
        word   = {func7, rs2, rs1, func3, rd, opcode};
      end
      FMT_I: begin
        opc_ok = (opcode == OP_IMM) || (opcode == OP_LOAD) || (opcode == OP_JALR);
        if (is_shift) begin
          // shamt lives in imm[4:0]; the upper word bits select SRLI/SRAI.
          rng_ok = (imm[31:5] == '0);
          word   = {func7, imm[4:0], rs1, func3, rd, opcode};
        end else begin
          rng_ok = fits12;
          word   = {imm[11:0], rs1, func3, rd, opcode};
        end
      end
      FMT_S: begin
        opc_ok = (opcode == OP_STORE);
        rng_ok = fits12;
        word   = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      end
      FMT_B: begin
        opc_ok = (opcode == OP_BRANCH);
        rng_ok = fits13 && !imm[0];
        word   = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
      end
      FMT_U: begin
        opc_ok = (opcode == OP_LUI) || (opcode == OP_AUIPC);
        rng_ok = (imm[11:0] == '0);
        word   = {imm[31:12], rd, opcode};
      end
      FMT_J: begin
        opc_ok = (opcode == OP_JAL);
        rng_ok = fits21 && !imm[0];
        word   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      end
      default: begin
        fmt_ok = 1'b0;
      end
    endcase

    if (!fmt_ok) begin
      code = ERR_FMT;
    end else if (!opc_ok) begin
      code = ERR_OPC;
    end else if (!rng_ok) begin
      code = ERR_RANGE;
    end else begin
      code = ERR_NONE;
    end
    ok = (code == ERR_NONE);
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I encoder writing packed words into
// instruction memory at an auto-incrementing byte address.
//   clk, rst_n (sync, active-low), clr (sync soft clear, highest priority)
//   req_*  - decoded fields in, valid/ready handshake
//   wr_*   - one-entry output register towards instruction memory
//   err    - one-cycle pulse after a rejected request
//   err_code - reason of the last rejection, held
//   n_words  - saturating count of words written
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_fmt,
  input  logic [6:0]        req_opcode,
  input  logic [2:0]        req_func3,
  input  logic [6:0]        req_func7,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [15:0]       n_words
);

  logic [31:0] pk_word;
  logic        pk_ok;
  logic [1:0]  pk_code;
  logic        accept;
  logic        write;

  instr_pack u_pack (
    .fmt    (req_fmt),
    .opcode (req_opcode),
    .func3  (req_func3),
    .func7  (req_func7),
    .rd     (req_rd),
    .rs1    (req_rs1),
    .rs2    (req_rs2),
    .imm    (req_imm),
    .word   (pk_word),
    .ok     (pk_ok),
    .code   (pk_code)
  );

  assign req_ready = rst_n && !clr && (!wr_valid || wr_ready);
  assign accept    = req_valid && req_ready;
  assign write     = wr_valid && wr_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_valid <= 1'b0;
      wr_addr  <= BASE_ADDR;
      wr_data  <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      n_words  <= '0;
    end else if (clr) begin
      wr_valid <= 1'b0;
      wr_addr  <= BASE_ADDR;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      n_words  <= '0;
    end else begin
      err <= 1'b0;
      if (write) begin
        wr_valid <= 1'b0;
        wr_addr  <= wr_addr + ADDR_W'(4);
        if (n_words != 16'hFFFF) begin
          n_words <= n_words + 16'd1;
        end
      end
      // Acceptance implies the register is empty or drains this cycle, so a
      // legal word may overwrite the write-clear above; a rejection leaves it.
      if (accept) begin
        if (pk_ok) begin
          wr_valid <= 1'b1;
          wr_data  <= pk_word;
        end else begin
          err      <= 1'b1;
          err_code <= pk_code;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clr, req_valid, wr_ready;
  logic [2:0]  req_fmt, req_func3;
  logic [6:0]  req_opcode, req_func7;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;

  logic        a_req_ready, a_wr_valid, a_err;
  logic [31:0] a_wr_addr, a_wr_data;
  logic [1:0]  a_err_code;
  logic [15:0] a_n_words;

  logic        b_req_ready, b_wr_valid, b_err;
  logic [3:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic [1:0]  b_err_code;
  logic [15:0] b_n_words;

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h100)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_fmt(req_fmt), .req_opcode(req_opcode), .req_func3(req_func3), .req_func7(req_func7),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .wr_valid(a_wr_valid), .wr_ready(wr_ready), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .err(a_err), .err_code(a_err_code), .n_words(a_n_words)
  );

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'h8)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_fmt(req_fmt), .req_opcode(req_opcode), .req_func3(req_func3), .req_func7(req_func7),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .wr_valid(b_wr_valid), .wr_ready(wr_ready), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .err(b_err), .err_code(b_err_code), .n_words(b_n_words)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference encoder written straight from the ISA rules with integer arithmetic.
  function automatic void ref_encode(input logic [31:0] fmt, input logic [31:0] opc,
                                     input logic [31:0] f3, input logic [31:0] f7,
                                     input logic [31:0] rd, input logic [31:0] rs1,
                                     input logic [31:0] rs2, input logic [31:0] u,
                                     output logic [31:0] w, output int c);
    int s;
    bit legal, inr, shift;
    s = $signed(u);
    w = 0;
    c = 0;
    if (fmt > 5) begin c = 1; return; end
    case (fmt)
      0: legal = (opc == 32'h33);
      1: legal = opc inside {32'h13, 32'h03, 32'h67};
      2: legal = (opc == 32'h23);
      3: legal = (opc == 32'h63);
      4: legal = opc inside {32'h37, 32'h17};
      default: legal = (opc == 32'h6F);
    endcase
    if (!legal) begin c = 2; return; end
    shift = (fmt == 1) && (opc == 32'h13) && (f3 == 1 || f3 == 5);
    case (fmt)
      0: inr = 1;
      1: inr = shift ? (s >= 0 && s <= 31) : (s >= -2048 && s <= 2047);
      2: inr = (s >= -2048 && s <= 2047);
      3: inr = (s >= -4096 && s <= 4094) && (s % 2 == 0);
      4: inr = ((u % 4096) == 0);
      default: inr = (s >= -(1 << 20) && s <= (1 << 20) - 2) && (s % 2 == 0);
    endcase
    if (!inr) begin c = 3; return; end
    case (fmt)
      0: w = f7 * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + opc;
      1: w = (shift ? f7 * 2**25 + (u % 32) * 2**20 : (u % 4096) * 2**20)
             + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + opc;
      2: w = ((u / 32) % 128) * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12
             + (u % 32) * 2**7 + opc;
      3: w = ((u / 4096) % 2) * 2**31 + ((u / 32) % 64) * 2**25 + rs2 * 2**20
             + rs1 * 2**15 + f3 * 2**12 + ((u / 2) % 16) * 2**8 + ((u / 2048) % 2) * 2**7 + opc;
      4: w = (u / 4096) * 4096 + rd * 2**7 + opc;
      default: w = ((u / 2**20) % 2) * 2**31 + ((u / 2) % 1024) * 2**21
                   + ((u / 2048) % 2) * 2**20 + ((u / 4096) % 256) * 2**12 + rd * 2**7 + opc;
    endcase
  endfunction

  // Transaction-level model: pending word, words written since clear, saturating count.
  bit          m_valid;
  logic [31:0] m_data;
  logic [31:0] m_k;
  int unsigned m_n;
  bit          m_err;
  int          m_code;

  function automatic void model_edge();
    logic [31:0] w;
    int c;
    bit rdy, acc, wr;
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_k = 0; m_n = 0; m_err = 0; m_code = 0;
      return;
    end
    if (clr) begin
      m_valid = 0; m_k = 0; m_n = 0; m_err = 0; m_code = 0;
      return;
    end
    rdy = !m_valid || wr_ready;
    acc = req_valid && rdy;
    wr  = m_valid && wr_ready;
    m_err = 0;
    if (wr) begin
      m_k = m_k + 1;
      if (m_n < 65535) m_n++;
      m_valid = 0;
    end
    if (acc) begin
      ref_encode(32'(req_fmt), 32'(req_opcode), 32'(req_func3), 32'(req_func7),
                 32'(req_rd), 32'(req_rs1), 32'(req_rs2), req_imm, w, c);
      if (c == 0) begin m_valid = 1; m_data = w; end
      else begin m_err = 1; m_code = c; end
    end
  endfunction

  task automatic cyc();
    bit exp_rdy;
    #1;
    exp_rdy = rst_n && !clr && (!m_valid || wr_ready);
    check("req_ready", 32'(a_req_ready), 32'(exp_rdy));
    check("b_req_ready", 32'(b_req_ready), 32'(exp_rdy));
    model_edge();
    @(posedge clk);
    #1;
    check("wr_valid", 32'(a_wr_valid), 32'(m_valid));
    check("wr_addr", a_wr_addr, 32'h100 + m_k * 4);
    check("wr_data", a_wr_data, m_data);
    check("err", 32'(a_err), 32'(m_err));
    check("err_code", 32'(a_err_code), 32'(m_code));
    check("n_words", 32'(a_n_words), m_n);
    check("b_wr_addr", 32'(b_wr_addr), (32'h8 + m_k * 4) % 16);
    check("b_wr_data", b_wr_data, m_data);
    check("b_wr_valid", 32'(b_wr_valid), 32'(m_valid));
    check("b_n_words", 32'(b_n_words), m_n);
  endtask

  task automatic set_req(input int f, input int opc, input int f3, input int f7,
                         input int rd, input int rs1, input int rs2, input logic [31:0] imm);
    req_valid  = 1'b1;
    req_fmt    = 3'(f);
    req_opcode = 7'(opc);
    req_func3  = 3'(f3);
    req_func7  = 7'(f7);
    req_rd     = 5'(rd);
    req_rs1    = 5'(rs1);
    req_rs2    = 5'(rs2);
    req_imm    = imm;
  endtask

  task automatic rand_req();
    int f;
    f = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
    req_valid  = ($urandom_range(0, 3) != 0);
    req_fmt    = 3'(f);
    req_func3  = 3'($urandom);
    req_func7  = 7'($urandom);
    req_rd     = 5'($urandom);
    req_rs1    = 5'($urandom);
    req_rs2    = 5'($urandom);
    case (f)
      0: req_opcode = 7'h33;
      1: req_opcode = ($urandom_range(0, 1) == 0) ? 7'h13 : (($urandom_range(0, 1) == 0) ? 7'h03 : 7'h67);
      2: req_opcode = 7'h23;
      3: req_opcode = 7'h63;
      4: req_opcode = ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17;
      5: req_opcode = 7'h6F;
      default: req_opcode = 7'($urandom);
    endcase
    if ($urandom_range(0, 7) == 0) req_opcode = 7'($urandom);
    case ($urandom_range(0, 4))
      0: req_imm = $urandom;
      1: req_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: req_imm = 32'($urandom_range(0, 40));
      3: req_imm = $urandom & 32'hFFFFF000;
      default: req_imm = 32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000;
    endcase
  endtask

  typedef struct {
    int f, opc, f3, f7, rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  vec_t basic [7];
  logic [31:0] hold_data, hold_addr;

  initial begin
    basic[0] = '{1, 32'h13, 0, 0,    1, 0, 0, 32'd5,        32'h00500093};
    basic[1] = '{0, 32'h33, 0, 0,    3, 1, 2, 32'd0,        32'h002081B3};
    basic[2] = '{0, 32'h33, 0, 32'h20, 3, 1, 2, 32'd0,      32'h402081B3};
    basic[3] = '{2, 32'h23, 2, 0,    0, 1, 2, 32'd8,        32'h0020A423};
    basic[4] = '{3, 32'h63, 0, 0,    0, 1, 2, 32'd8,        32'h00208463};
    basic[5] = '{5, 32'h6F, 0, 0,    1, 0, 0, 32'd16,       32'h010000EF};
    basic[6] = '{4, 32'h37, 0, 0,    5, 0, 0, 32'h12345000, 32'h123452B7};

    rst_n = 1'b0; clr = 1'b0; wr_ready = 1'b1;
    set_req(0, 32'h33, 0, 0, 0, 0, 0, 0);
    req_valid = 1'b0;
    cyc(); cyc();
    check("rst_wr_addr", a_wr_addr, 32'h100);
    check("rst_wr_data", a_wr_data, 32'h0);
    rst_n = 1'b1;
    cyc();
    check("ready_after_rst", 32'(a_req_ready), 32'd1);

    // Basic encodes, streamed back to back.
    for (int i = 0; i < 7; i++) begin
      set_req(basic[i].f, basic[i].opc, basic[i].f3, basic[i].f7,
              basic[i].rd, basic[i].rs1, basic[i].rs2, basic[i].imm);
      cyc();
      check("enc_word", a_wr_data, basic[i].word);
    end
    req_valid = 1'b0;
    cyc();

    // Five-word stream after a clear.
    clr = 1'b1; cyc(); clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(1, 32'h13, 0, 0, i + 1, 0, 0, 32'(i));
      cyc();
      check("stream_addr", a_wr_addr, 32'h100 + 32'(i) * 4);
    end
    req_valid = 1'b0;
    cyc();
    check("stream_count", 32'(a_n_words), 32'd5);

    // Backpressure.
    wr_ready = 1'b0;
    set_req(0, 32'h33, 0, 0, 7, 8, 9, 0);
    cyc();
    hold_data = a_wr_data; hold_addr = a_wr_addr;
    set_req(0, 32'h33, 0, 0, 10, 11, 12, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_ready", 32'(a_req_ready), 32'd0);
      check("stall_data", a_wr_data, hold_data);
      check("stall_addr", a_wr_addr, hold_addr);
    end
    wr_ready = 1'b1;
    cyc();
    check("bp_write1", 32'(a_n_words), 32'd6);
    req_valid = 1'b0;
    cyc();
    check("bp_write2", 32'(a_n_words), 32'd7);

    // Range, format and opcode errors.
    hold_addr = a_wr_addr;
    set_req(1, 32'h13, 0, 0, 1, 0, 0, 32'd2048);
    cyc();
    check("rng_err", 32'(a_err), 32'd1);
    check("rng_code", 32'(a_err_code), 32'd3);
    check("rng_addr", a_wr_addr, hold_addr);
    set_req(3, 32'h63, 0, 0, 0, 1, 2, 32'd6);
    cyc();
    check("beq6_ok", 32'(a_wr_valid), 32'd1);
    set_req(3, 32'h63, 0, 0, 0, 1, 2, 32'd7);
    cyc();
    check("beq7_code", 32'(a_err_code), 32'd3);
    check("beq7_novalid", 32'(a_wr_valid), 32'd0);
    set_req(3, 32'h33, 0, 0, 0, 1, 2, 32'd8);
    cyc();
    check("opc_code", 32'(a_err_code), 32'd2);
    set_req(7, 32'h33, 0, 0, 0, 1, 2, 32'd8);
    cyc();
    check("fmt_code", 32'(a_err_code), 32'd1);
    req_valid = 1'b0;
    cyc();
    check("err_pulse_end", 32'(a_err), 32'd0);
    check("err_code_held", 32'(a_err_code), 32'd1);

    // Clear during a stall.
    wr_ready = 1'b0;
    set_req(1, 32'h13, 0, 0, 1, 0, 0, 32'd1);
    cyc(); cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("clr_valid", 32'(a_wr_valid), 32'd0);
    check("clr_addr", a_wr_addr, 32'h100);
    check("clr_count", 32'(a_n_words), 32'd0);

    // Wrap on the 4-bit address instance.
    wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(4, 32'h17, 0, 0, i, 0, 0, 32'h1000);
      cyc();
      check("wrap_addr", 32'(b_wr_addr), (i == 0) ? 32'h8 : (i == 1) ? 32'hC : 32'h0);
    end
    req_valid = 1'b0;
    cyc();

    // Reset mid-stall.
    wr_ready = 1'b0;
    set_req(5, 32'h6F, 0, 0, 1, 0, 0, 32'd4);
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("rst_stall_valid", 32'(a_wr_valid), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rand_req();
      wr_ready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 63) == 0);
      cyc();
    end
    clr = 1'b0;
    req_valid = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
